// File: rtl/led_breathe.sv
// Breathing-LED driver: blink-signal rising edges step a duty value through
// rise/peak/fall/trough, and a free-running PWM drives the LED. Optional gamma via LED_BREATHE_GAMMA_EN.
module led_breathe #(
  parameter int PWM_BITS   = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                tick_in,
  input  logic                enable,
  output logic                led_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          state
);

  localparam int DMAX = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS:0]   DMAX_W = (PWM_BITS+1)'(DMAX);
  localparam logic [PWM_BITS-1:0] DMAX_P = PWM_BITS'(DMAX);
  localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(STEP);
  localparam logic [PWM_BITS-1:0] STEP_P = PWM_BITS'(STEP);
  localparam logic [8:0]          HOLD_W = 9'(HOLD_TICKS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RISE   = 3'd1,
    S_PEAK   = 3'd2,
    S_FALL   = 3'd3,
    S_TROUGH = 3'd4
  } state_t;

  state_t              r_state, w_stateNext;
  logic [PWM_BITS-1:0] r_duty, w_dutyNext;
  logic [7:0]          r_hold, w_holdNext;
  logic                r_tickDly;
  logic                w_tick;
  logic [PWM_BITS:0]   w_riseSum;
  logic [PWM_BITS-1:0] w_riseDuty;
  logic [PWM_BITS-1:0] w_fallDuty;
  logic                w_holdDone;
  logic [PWM_BITS-1:0] w_effDuty;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic [PWM_BITS-1:0] r_dutyActive;
  logic                w_pwmWrap;

  // tick delay resets high so a blink input already high at release is not an edge
  assign w_tick     = tick_in & ~r_tickDly;
  assign w_riseSum  = {1'b0, r_duty} + STEP_W;
  assign w_riseDuty = (w_riseSum > DMAX_W) ? DMAX_P : w_riseSum[PWM_BITS-1:0];
  assign w_fallDuty = ({1'b0, r_duty} > STEP_W) ? (r_duty - STEP_P) : '0;
  assign w_holdDone = (({1'b0, r_hold} + 9'd1) == HOLD_W);

`ifdef LED_BREATHE_GAMMA_EN
  logic [2*PWM_BITS:0] w_dutyWide;
  logic [2*PWM_BITS:0] w_prod;
  assign w_dutyWide = (2*PWM_BITS+1)'(r_duty);
  assign w_prod     = w_dutyWide * (w_dutyWide + (2*PWM_BITS+1)'(1));
  assign w_effDuty  = PWM_BITS'(w_prod >> PWM_BITS);
`else
  assign w_effDuty  = r_duty;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_duty    <= '0;
      r_hold    <= '0;
      r_tickDly <= 1'b1;
    end else begin
      r_state   <= w_stateNext;
      r_duty    <= w_dutyNext;
      r_hold    <= w_holdNext;
      r_tickDly <= tick_in;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_dutyNext  = r_duty;
    w_holdNext  = r_hold;
    if (!enable) begin
      w_stateNext = S_IDLE;
      w_dutyNext  = '0;
      w_holdNext  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_stateNext = S_RISE;
          w_dutyNext  = '0;
          w_holdNext  = '0;
        end
        S_RISE: if (w_tick) begin
          w_dutyNext = w_riseDuty;
          if (w_riseDuty == DMAX_P) begin
            w_stateNext = S_PEAK;
            w_holdNext  = '0;
          end
        end
        S_PEAK: if (w_tick) begin
          if (w_holdDone) begin
            w_stateNext = S_FALL;
            w_holdNext  = '0;
          end else begin
            w_holdNext = r_hold + 8'd1;
          end
        end
        S_FALL: if (w_tick) begin
          w_dutyNext = w_fallDuty;
          if (w_fallDuty == '0) begin
            w_stateNext = S_TROUGH;
            w_holdNext  = '0;
          end
        end
        S_TROUGH: if (w_tick) begin
          if (w_holdDone) begin
            w_stateNext = S_RISE;
            w_holdNext  = '0;
          end else begin
            w_holdNext = r_hold + 8'd1;
          end
        end
        default: begin
          w_stateNext = S_IDLE;
          w_dutyNext  = '0;
          w_holdNext  = '0;
        end
      endcase
    end
  end

  // duty is latched only at the period boundary so a mid-period step never glitches the LED
  assign w_pwmWrap = (r_pwmCnt == PWM_BITS'(DMAX - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pwmCnt     <= '0;
      r_dutyActive <= '0;
      led_out      <= 1'b0;
    end else begin
      r_pwmCnt <= w_pwmWrap ? '0 : (r_pwmCnt + PWM_BITS'(1));
      if (!enable)
        r_dutyActive <= '0;
      else if (w_pwmWrap)
        r_dutyActive <= w_effDuty;
      led_out <= enable & (r_pwmCnt < r_dutyActive);
    end
  end

  assign duty  = r_duty;
  assign state = r_state;

endmodule

// File: tb/tb_led_breathe.sv
// Randomised scoreboard bench for led_breathe: a precomputed breathing sequence
// predicts state/duty changes, and per-period LED high counts are checked.
module tb_led_breathe;

`ifdef LED_BREATHE_GAMMA_EN
  localparam int PB   = 8;
  localparam int STEP = 32;
`else
  localparam int PB   = 4;
  localparam int STEP = 5;
`endif
  localparam int HOLD = 2;
  localparam int DMAX = (1 << PB) - 1;
  localparam int PER  = DMAX;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          tick_in = 1'b0;
  logic          enable = 1'b0;
  logic          led_out;
  logic [PB-1:0] duty;
  logic [2:0]    state;

  led_breathe #(.PWM_BITS(PB), .STEP(STEP), .HOLD_TICKS(HOLD)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .tick_in (tick_in),
    .enable  (enable),
    .led_out (led_out),
    .duty    (duty),
    .state   (state)
  );

  always #5 clock = ~clock;

  typedef struct { int st; int du; } vis_t;
  typedef struct { int closeEdge; int cnt; } pwm_t;

  vis_t seq[$];
  vis_t expQ[$];
  pwm_t pwmQ[$];
  vis_t lastPushed;
  vis_t lastObs;
  int   seqIdx = 0;
  bit   mEn = 1'b0;
  bit   monEn = 1'b0;
  int   checks = 0;
  int   fails = 0;
  int   edgeNum = 0;
  int   lastLowEdge = 0;
  int   ledAcc = 0;

  function automatic int effDuty(input int d);
`ifdef LED_BREATHE_GAMMA_EN
    return (d * (d + 1)) >> PB;
`else
    return d;
`endif
  endfunction

  // One full breathing cycle as the visible (state, duty) after each tick; wraps to entry 0
  function automatic void buildSeq();
    int d;
    d = 0;
    seq.push_back('{1, 0});
    while (d < DMAX) begin
      d = (d + STEP > DMAX) ? DMAX : d + STEP;
      seq.push_back('{(d == DMAX) ? 2 : 1, d});
    end
    for (int h = 1; h < HOLD; h++) seq.push_back('{2, DMAX});
    seq.push_back('{3, DMAX});
    while (d > 0) begin
      d = (d - STEP < 0) ? 0 : d - STEP;
      seq.push_back('{(d == 0) ? 4 : 3, d});
    end
    for (int h = 1; h < HOLD; h++) seq.push_back('{4, 0});
  endfunction

  function automatic vis_t modelVis();
    vis_t v;
    if (!mEn) v = '{0, 0};
    else      v = seq[seqIdx];
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExpect();
    vis_t v;
    v = modelVis();
    if (v.st != lastPushed.st || v.du != lastPushed.du) begin
      expQ.push_back(v);
      lastPushed = v;
    end
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Drive tick/enable just after an edge, update the model once the DUT has clocked it
  task automatic applyStimulus(input bit doTick, input bit en, input int highCycles);
    tick_in = doTick;
    enable  = en;
    @(posedge clock);
    #1;
    if (!en)
      mEn = 1'b0;
    else if (!mEn) begin
      mEn    = 1'b1;
      seqIdx = 0;
    end else if (doTick)
      seqIdx = (seqIdx + 1) % seq.size();
    pushExpect();
    if (highCycles > 1) waitEdges(highCycles - 1);
    tick_in = 1'b0;
    waitEdges(1);
  endtask

  always @(posedge clock) begin
    if (reset_n) begin
      edgeNum++;
      if (!enable) lastLowEdge = edgeNum;
    end
  end

  // Monitor: pop expected state/duty on every visible change; tally LED highs per PWM period
  always @(negedge clock) begin
    if (monEn) begin
      if (int'(state) != lastObs.st || int'(duty) != lastObs.du) begin
        lastObs = '{int'(state), int'(duty)};
        if (expQ.size() == 0) begin
          checkOutput("spurious_state", int'(state), lastPushed.st);
          checkOutput("spurious_duty", int'(duty), lastPushed.du);
        end else begin
          vis_t e;
          e = expQ.pop_front();
          checkOutput("state", int'(state), e.st);
          checkOutput("duty", int'(duty), e.du);
        end
      end
      if (edgeNum % PER == PER - 1) begin
        vis_t v;
        v = modelVis();
        pwmQ.push_back('{edgeNum + PER + 1, effDuty(v.du)});
      end
      if (edgeNum % PER == 1) ledAcc = int'(led_out);
      else                    ledAcc += int'(led_out);
      if (edgeNum % PER == 0 && pwmQ.size() > 0 && pwmQ[0].closeEdge == edgeNum) begin
        pwm_t p;
        p = pwmQ.pop_front();
        if (lastLowEdge < edgeNum - PER)
          checkOutput("pwm_high_cycles", ledAcc, p.cnt);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int gap;
    buildSeq();
    lastPushed = '{0, 0};
    lastObs    = '{0, 0};

    // reset held with the blink input high
    reset_n = 1'b0;
    tick_in = 1'b1;
    enable  = 1'b0;
    #23;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_duty", int'(duty), 0);
    checkOutput("reset_led", int'(led_out), 0);
    #4;
    reset_n = 1'b1;
    waitEdges(3);
    checkOutput("post_reset_state", int'(state), 0);
    checkOutput("post_reset_duty", int'(duty), 0);
    checkOutput("post_reset_led", int'(led_out), 0);
    monEn = 1'b1;

    // enable with tick_in still high: enters RISE at duty 0, no step
    applyStimulus(1'b1, 1'b1, 4);

    // one deterministic full breathing cycle, then step up twice
    for (int i = 0; i < seq.size() + 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1);
      waitEdges(2 + (i % 7));
    end

    // enable drops in the same cycle as a tick
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("drop_led", int'(led_out), 0);
    checkOutput("drop_state", int'(state), 0);
    checkOutput("drop_duty", int'(duty), 0);
    waitEdges(PER + 3);
    applyStimulus(1'b0, 1'b1, 1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0)
        applyStimulus(1'b0, ~enable, 1);
      else
        applyStimulus(1'b1, enable, $urandom_range(1, 3));
      if ($urandom_range(0, 5) == 0)
        gap = $urandom_range(2 * PER, 2 * PER + 20);
      else
        gap = $urandom_range(0, 20);
      if (gap > 0) waitEdges(gap);
    end

    waitEdges(2 * PER + 4);
    monEn = 1'b0;
    checkOutput("state_missing", expQ.size(), 0);

    // reset asserted mid-ramp clears everything immediately
    enable = 1'b1;
    waitEdges(2);
    tick_in = 1'b1;
    waitEdges(1);
    tick_in = 1'b0;
    waitEdges(PER + 2);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_state", int'(state), 0);
    checkOutput("midreset_duty", int'(duty), 0);
    checkOutput("midreset_led", int'(led_out), 0);
    #3;
    reset_n = 1'b1;
    waitEdges(1);
    checkOutput("restart_state", int'(state), 1);
    checkOutput("restart_duty", int'(duty), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
